fp_pipe_wrapper: RTL and testbench
==================================

# fp_pipe_wrapper

- Generic handshake wrapper around any fixed-latency, clock-enabled floating-point core (exp, add, mul, div, sqrt megafunctions) in the effects datapath.
- Accepts a new operation every cycle, keeps up to LATENCY operations in flight, and carries a tag alongside each one.
- Freezes the core through its clock enable when the consumer back-pressures, instead of waiting a fixed count per operation.
- The core is instantiated beside the wrapper and connected through the core_* ports.

## Interface
Parameters:
- LATENCY, 17: core latency in enabled clock edges; must be at least 1.
- DATA_W, 32: operand and result width (IEEE-754 single).
- TAG_W, 4: width of the user tag carried with each operation.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  wrapper can accept the request this cycle.
- in_dataa  in  DATA_W  operand A.
- in_datab  in  DATA_W  operand B (unused by single-operand cores).
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  DATA_W  result.
- out_tag  out  TAG_W  tag of the result.
- busy_count  out  $clog2(LATENCY+2)  operations in the pipe plus the output register.
- idle  out  1  busy_count == 0.
- core_clk_en  out  1  core clock enable.
- core_dataa  out  DATA_W  equals in_dataa (combinational).
- core_datab  out  DATA_W  equals in_datab (combinational).
- core_result  in  DATA_W  core output.

## Operation
- Tracking pipe: a valid shift register vsr[0..LATENCY-1] and a matching tag shift register. Both advance only on edges where core_clk_en=1.
  - vsr[0] loads the accept condition (in_valid && in_ready).
  - vsr[i] loads vsr[i-1].
- Stall condition: stall = vsr[LATENCY-1] && out_valid && !out_ready.
- Clock enable: core_clk_en = !stall. in_ready = !stall && !reset.
- Capture: when vsr[LATENCY-1]=1 and stall=0, the output register loads core_result and tag[LATENCY-1], and sets out_valid=1.
- Clear: otherwise, out_valid clears on out_ready=1; if neither applies, it holds.
- Simultaneous drain and capture: out_ready=1 together with a pending capture replaces the output register in the same edge. No bubble is inserted and nothing is lost.
- Bubbles: bubbles in the pipe are not collapsed during a stall; the whole pipe freezes.
- busy_count: +1 on accept, −1 on output handshake, unchanged when both occur in the same cycle. It never exceeds LATENCY+1.
- Ordering: results leave strictly in acceptance order, each with its own tag.
- Reset (including mid-operation):
  - vsr, tags, out_valid and busy_count clear to 0; in_ready=0; core_clk_en=1.
  - In-flight core contents are discarded because their valid bits are gone; no result from before reset may ever appear on out_valid.

## Timing
- Reset values: out_valid=0, out_result=0, out_tag=0, busy_count=0, idle=1, core_clk_en=1. in_ready=0 while reset is high and 1 in the first cycle after.
- Latency: an operation accepted in cycle k shows out_valid=1 in cycle k+LATENCY+1 when no stall occurs. Each stalled cycle adds exactly one cycle.
- Throughput: one operation per cycle while out_ready is held high.
- Back-pressure: when the consumer holds out_ready=0, in_ready falls in the first cycle where a valid result is waiting behind a full output register. It rises in the same cycle out_ready returns to 1.
- Single-operation mode: in_valid pulsed with out_ready tied high gives the same start/done behaviour as a LATENCY-cycle wait.

## Structure
- Shared package fp_wrap_pkg:
  - FP_W=32.
  - DEFAULT_FP_LATENCY=17.
  - Per-core latency constants: FP_EXP_LAT, FP_ADD_LAT, FP_MUL_LAT, FP_DIV_LAT.
- Sub-module fp_valid_pipe: enable-gated valid+tag shift register, parameters LATENCY and TAG_W. The wrapper holds only the stall logic, the output register and the counter.

## Test plan
The bench core is a model whose result is dataa XOR datab, delayed by LATENCY enabled edges. Runs use LATENCY=17 and LATENCY=1.

- Single op: dataa=0x3F800000, datab=0x00000001, tag=3, accepted in cycle 10 → out_valid in cycle 28 only, result 0x3F800001, tag 3; busy_count 1 → 0 after the handshake.
- Streaming: 40 back-to-back ops with tags 0..15 wrapping, out_ready=1 → 40 results in order, one per cycle, with no gaps after the first.
- Back-pressure: out_ready=0 for 25 cycles mid-stream → no result lost or duplicated; busy_count peaks at 18; in_ready low exactly while stalled.
- Simultaneous events: out_ready=1 on the same edge a new result arrives → output register replaced, out_valid stays 1; an accept in the same cycle as the drain leaves busy_count unchanged.
- Reset mid-stream: reset for 1 cycle with 10 ops in flight → out_valid=0 and busy_count=0 afterwards, and none of the 10 results ever appear; the next op completes normally after LATENCY+1 cycles.

Source files
------------

// File: rtl/fp_wrap_pkg.sv
// fp_wrap_pkg: shared constants for the handshake wrappers around
// the fixed-latency floating-point cores of the effects datapath.
package fp_wrap_pkg;

    localparam int FP_W = 32;
    localparam int DEFAULT_FP_LATENCY = 17;

    // Enabled-edge latencies of the generated megafunctions
    localparam int FP_EXP_LAT = 17;
    localparam int FP_ADD_LAT = 7;
    localparam int FP_MUL_LAT = 5;
    localparam int FP_DIV_LAT = 6;

    function automatic int busy_w(input int lat);
        return $clog2(lat + 2);
    endfunction

endpackage

// File: rtl/fp_valid_pipe.sv
// fp_valid_pipe: enable-gated valid + tag shift register that tracks
// which core pipeline stages hold a live operation.
module fp_valid_pipe
    import fp_wrap_pkg::*;
#(
    parameter int LATENCY = DEFAULT_FP_LATENCY,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic [LATENCY-1:0] vsr;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            vsr <= '0;
            for (int i = 0; i < LATENCY; i++)
                tag_q[i] <= '0;
        end else if (en) begin
            vsr[0]   <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vsr[i]   <= vsr[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vsr[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/fp_pipe_wrapper.sv
// fp_pipe_wrapper: valid/ready wrapper for a fixed-latency clock-enabled
// FP core; back-pressure freezes the core instead of dropping results.
module fp_pipe_wrapper
    import fp_wrap_pkg::*;
#(
    parameter int LATENCY = DEFAULT_FP_LATENCY,
    parameter int DATA_W  = FP_W,
    parameter int TAG_W   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_dataa,
    input  logic [DATA_W-1:0]           in_datab,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic [TAG_W-1:0]            out_tag,
    output logic [busy_w(LATENCY)-1:0]  busy_count,
    output logic                        idle,
    output logic                        core_clk_en,
    output logic [DATA_W-1:0]           core_dataa,
    output logic [DATA_W-1:0]           core_datab,
    input  logic [DATA_W-1:0]           core_result
);

    localparam int BW = busy_w(LATENCY);
    localparam logic [BW-1:0] BUSY_ONE = BW'(1);

    logic             pipe_valid;
    logic [TAG_W-1:0] pipe_tag;
    logic             stall;
    logic             accept;
    logic             drain;
    logic             capture;

    assign stall   = pipe_valid && out_valid && !out_ready;
    assign accept  = in_valid && in_ready;
    assign drain   = out_valid && out_ready;
    assign capture = pipe_valid && !stall;

    // Keep the core running through reset so stale stages flush out
    assign core_clk_en = !stall || reset;
    assign in_ready    = !stall && !reset;
    assign idle        = (busy_count == '0);
    assign core_dataa  = in_dataa;
    assign core_datab  = in_datab;

    fp_valid_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_vpipe (
        .clock     (clock),
        .reset     (reset),
        .en        (core_clk_en),
        .in_valid  (accept),
        .in_tag    (in_tag),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= core_result;
            out_tag    <= pipe_tag;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            busy_count <= '0;
        else if (accept && !drain)
            busy_count <= busy_count + BUSY_ONE;
        else if (drain && !accept)
            busy_count <= busy_count - BUSY_ONE;
    end

endmodule

// File: tb/tb_fp_pipe_wrapper.sv
// tb_fp_pipe_wrapper: directed bench driving LATENCY=17 and LATENCY=1
// wrappers in parallel, each around an XOR core model.
module tb_fp_pipe_wrapper;

    localparam int L17 = 17;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_dataa;
    logic [31:0] in_datab;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, idle_a, en_a;
    logic [31:0] out_result_a, cda_a, cdb_a, cres_a;
    logic [3:0]  out_tag_a;
    logic [4:0]  busy_a;

    logic        in_ready_b, out_valid_b, idle_b, en_b;
    logic [31:0] out_result_b, cda_b, cdb_b, cres_b;
    logic [3:0]  out_tag_b;
    logic [1:0]  busy_b;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic [31:0] pa [L17];
    logic [31:0] pb;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fp_pipe_wrapper #(.LATENCY(L17), .DATA_W(32), .TAG_W(4)) u17 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_dataa(in_dataa), .in_datab(in_datab), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_result(out_result_a), .out_tag(out_tag_a),
        .busy_count(busy_a), .idle(idle_a), .core_clk_en(en_a),
        .core_dataa(cda_a), .core_datab(cdb_a), .core_result(cres_a)
    );

    fp_pipe_wrapper #(.LATENCY(1), .DATA_W(32), .TAG_W(4)) u1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_dataa(in_dataa), .in_datab(in_datab), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_result(out_result_b), .out_tag(out_tag_b),
        .busy_count(busy_b), .idle(idle_b), .core_clk_en(en_b),
        .core_dataa(cda_b), .core_datab(cdb_b), .core_result(cres_b)
    );

    // Core models: dataa ^ datab, delayed by LATENCY enabled edges
    always @(posedge clock) begin
        if (en_a) begin
            pa[0] <= cda_a ^ cdb_a;
            for (int i = 1; i < L17; i++)
                pa[i] <= pa[i-1];
        end
        if (en_b)
            pb <= cda_b ^ cdb_b;
    end
    assign cres_a = pa[L17-1];
    assign cres_b = pb;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards: order, data and tag of every output handshake
    always @(negedge clock) begin
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0)
                    check("sb17_spurious", {out_tag_a, out_result_a}, 0);
                else
                    check("sb17_order", {out_tag_a, out_result_a},
                          qa.pop_front());
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0)
                    check("sb1_spurious", {out_tag_b, out_result_b}, 0);
                else
                    check("sb1_order", {out_tag_b, out_result_b},
                          qb.pop_front());
            end
            if (in_valid && in_ready_a)
                qa.push_back({in_tag, in_dataa ^ in_datab});
            if (in_valid && in_ready_b)
                qb.push_back({in_tag, in_dataa ^ in_datab});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_stream(input string nm, input int n,
                              input logic [31:0] base,
                              input int sa, input int sl);
        int j = 0, na = 0, nb = 0, fa = -1, la = -1;
        int fb = -1, lb = -1, pka = 0, pkb = 0;
        logic acc, hold;
        for (int c = 0; c < 110; c++) begin
            hold      = (c >= sa) && (c < sa + sl);
            out_ready = !hold;
            in_valid  = (j < n);
            in_dataa  = base + 32'(j);
            in_datab  = 32'(j) * 32'h0101_0101;
            in_tag    = 4'(j);
            @(negedge clock);
            check({nm, "_ready17"}, in_ready_a, !hold);
            check({nm, "_ready1"}, in_ready_b, !hold);
            if (c == 30)
                check({nm, "_busy_c30"}, busy_a, 18);
            if (int'(busy_a) > pka) pka = int'(busy_a);
            if (int'(busy_b) > pkb) pkb = int'(busy_b);
            if (out_valid_a && out_ready) begin
                if (fa < 0) fa = c;
                la = c;
                na++;
            end
            if (out_valid_b && out_ready) begin
                if (fb < 0) fb = c;
                lb = c;
                nb++;
            end
            acc = in_valid && in_ready_a;
            step();
            if (acc) j++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({nm, "_accepted"}, j, n);
        check({nm, "_nout17"}, na, n);
        check({nm, "_nout1"}, nb, n);
        check({nm, "_first17"}, fa, 18);
        check({nm, "_first1"}, fb, 2);
        check({nm, "_peak17"}, pka, 18);
        check({nm, "_peak1"}, pkb, 2);
        check({nm, "_sb_empty"}, qa.size() + qb.size(), 0);
        check({nm, "_idle"}, {idle_a, idle_b}, 2'b11);
        if (sl == 0) begin
            check({nm, "_nogap17"}, la - fa, n - 1);
            check({nm, "_nogap1"}, lb - fb, n - 1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dataa  = '0;
        in_datab  = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clock);
        check("rst_ready", {in_ready_a, in_ready_b}, 2'b00);
        check("rst_clk_en", {en_a, en_b}, 2'b11);
        check("rst_ovalid", {out_valid_a, out_valid_b}, 2'b00);
        check("rst_result", out_result_a, 0);
        check("rst_tag", out_tag_a, 0);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_idle", {idle_a, idle_b}, 2'b11);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {in_ready_a, in_ready_b}, 2'b11);

        // Single op accepted in cycle 10
        while (cyc < 10) step();
        in_valid = 1'b1;
        in_dataa = 32'h3F80_0000;
        in_datab = 32'h0000_0001;
        in_tag   = 4'd3;
        @(negedge clock);
        check("single_acc", {in_ready_a, busy_a}, {1'b1, 5'd0});
        step();
        in_valid = 1'b0;
        for (int c = 11; c <= 30; c++) begin
            @(negedge clock);
            check("single_ov17", out_valid_a, cyc == 28);
            check("single_ov1", out_valid_b, cyc == 12);
            if (cyc == 11)
                check("single_busy_in", busy_a, 1);
            if (cyc == 28) begin
                check("single_res17", out_result_a, 32'h3F80_0001);
                check("single_tag17", out_tag_a, 3);
                check("single_busy17", busy_a, 1);
            end
            if (cyc == 29)
                check("single_done17", {busy_a, idle_a}, {5'd0, 1'b1});
            if (cyc == 12)
                check("single_res1", {out_tag_b, out_result_b},
                      {4'd3, 32'h3F80_0001});
            if (cyc == 13)
                check("single_done1", {busy_b, idle_b}, {2'd0, 1'b1});
            step();
        end

        // Streaming, then back-pressure mid-stream
        run_stream("stream", 40, 32'h1000_0000, 200, 0);
        run_stream("bp", 40, 32'h2000_0000, 20, 25);

        // Reset with 10 ops in flight
        for (int j = 0; j < 10; j++) begin
            in_valid = 1'b1;
            in_dataa = 32'h7000_0000 + 32'(j);
            in_datab = 32'hDEAD_0000;
            in_tag   = 4'(j + 5);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("mid_rst_ready", in_ready_a, 0);
        check("mid_rst_clk_en", en_a, 1);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("after_rst", {out_valid_a, busy_a, idle_a},
              {1'b0, 5'd0, 1'b1});
        check("after_rst1", {out_valid_b, busy_b}, 0);
        in_valid = 1'b1;
        in_dataa = 32'h4040_0000;
        in_datab = 32'h0000_00FF;
        in_tag   = 4'd9;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                step();
                in_valid = 1'b0;
                @(negedge clock);
            end
            check("rst_ov17", out_valid_a, c == 18);
            check("rst_ov1", out_valid_b, c == 2);
            if (c == 18)
                check("rst_res17", {out_tag_a, out_result_a},
                      {4'd9, 32'h4040_00FF});
        end
        step();
        check("final_idle", {idle_a, idle_b}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
